// File: rtl/gamma_temporal_encoder_pkg.sv
// gamma_pkg: shared types and sizing helpers for the gamma temporal encoder.
//   state_t          - controller states (IDLE, RUN)
//   channel_value_t  - one channel value at the default gamma width
//   value_width()    - bits needed to hold a tick/value for a gamma width
package gamma_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int unsigned DEFAULT_GAMMA_CYCLE_WIDTH = 16;
  localparam int unsigned DEFAULT_NUM_CHANNELS      = 16;
  localparam int unsigned DEFAULT_VALUE_WIDTH       = $clog2(DEFAULT_GAMMA_CYCLE_WIDTH);

  typedef logic [DEFAULT_VALUE_WIDTH-1:0] channel_value_t;

  function automatic int unsigned value_width(input int unsigned gamma_cycle_width);
    return (gamma_cycle_width < 2) ? 1 : $clog2(gamma_cycle_width);
  endfunction

endpackage

// File: rtl/gamma_temporal_encoder_if.sv
// Value-vector input bus of the gamma temporal encoder (valid/ready).
//   in_valid  - vector offered (master -> slave)
//   in_ready  - encoder shadow buffer free (slave -> master)
//   in_values - channel i in bits [i*VALUE_WIDTH +: VALUE_WIDTH]
//   in_null   - 1 = channel never spikes
interface gamma_temporal_encoder_if
  import gamma_pkg::*;
#(
  parameter int unsigned NUM_CHANNELS = DEFAULT_NUM_CHANNELS,
  parameter int unsigned VALUE_WIDTH  = DEFAULT_VALUE_WIDTH
);
  logic                            in_valid;
  logic                            in_ready;
  logic [NUM_CHANNELS*VALUE_WIDTH-1:0] in_values;
  logic [NUM_CHANNELS-1:0]         in_null;

  modport master (output in_valid, output in_values, output in_null, input  in_ready);
  modport slave  (input  in_valid, input  in_values, input  in_null, output in_ready);
endinterface

// File: rtl/gamma_temporal_encoder_temporal_channel.sv
// temporal_channel: one output line of the encoder. Holds the active value and
// null flag for the running gamma and raises spike once tick reaches value.
//   aclk, grst          - clock, synchronous active-high reset (clears to null)
//   load, load_value,
//   load_null           - replace the active value/null
//   run                 - encoder is in a running gamma
//   tick                - current tick within the gamma
//   spike               - temporal code output
module temporal_channel #(
  parameter int unsigned VALUE_WIDTH = 4
) (
  input  logic                   aclk,
  input  logic                   grst,
  input  logic                   load,
  input  logic [VALUE_WIDTH-1:0] load_value,
  input  logic                   load_null,
  input  logic                   run,
  input  logic [VALUE_WIDTH-1:0] tick,
  output logic                   spike
);
  logic [VALUE_WIDTH-1:0] value_q;
  logic                   null_q;

  always_ff @(posedge aclk) begin
    if (grst) begin
      value_q <= '0;
      null_q  <= 1'b1;
    end else if (load) begin
      value_q <= load_value;
      null_q  <= load_null;
    end
  end

  // Values beyond the last tick never satisfy the compare, so they act as null.
  always_comb begin
    spike = run && !null_q && (value_q <= tick);
  end
endmodule

// File: rtl/gamma_temporal_encoder.sv
// gamma_temporal_encoder: converts binary channel values into rising-edge
// temporal codes aligned to a gamma cycle, with a double-buffered input.
//   aclk        - clock
//   grst        - synchronous active-high reset
//   in_if       - value vector bus (slave): in_valid/in_ready/in_values/in_null
//   spikes      - one temporal line per channel
//   tick        - current tick within the gamma
//   gamma_start - high during tick 0 of each running gamma
//   busy        - high while a gamma runs
// Optional macro GAMMA_FREERUN_EN: counter runs continuously after reset, no
// IDLE state and no IDLE bypass; gammas without data emit no spikes.
module gamma_temporal_encoder
  import gamma_pkg::*;
#(
  parameter int unsigned GAMMA_CYCLE_WIDTH = DEFAULT_GAMMA_CYCLE_WIDTH,
  parameter int unsigned NUM_CHANNELS      = DEFAULT_NUM_CHANNELS,
  parameter int unsigned VALUE_WIDTH       = value_width(GAMMA_CYCLE_WIDTH)
) (
  input  logic                    aclk,
  input  logic                    grst,
  gamma_temporal_encoder_if.slave in_if,
  output logic [NUM_CHANNELS-1:0] spikes,
  output logic [VALUE_WIDTH-1:0]  tick,
  output logic                    gamma_start,
  output logic                    busy
);
  localparam logic [VALUE_WIDTH-1:0] TICK_LAST = VALUE_WIDTH'(GAMMA_CYCLE_WIDTH - 1);

  state_t                          state_q, state_d;
  logic [VALUE_WIDTH-1:0]          tick_q, tick_d;
  logic                            shadow_full_q, shadow_full_d;
  logic [NUM_CHANNELS*VALUE_WIDTH-1:0] shadow_values_q;
  logic [NUM_CHANNELS-1:0]         shadow_null_q;
  logic                            xfer, wrap;
  logic                            shadow_capture;
  logic                            load_en, load_from_shadow, load_clear;

  always_ff @(posedge aclk) begin
    if (grst) begin
`ifdef GAMMA_FREERUN_EN
      state_q <= RUN;
`else
      state_q <= IDLE;
`endif
      tick_q          <= '0;
      shadow_full_q   <= 1'b0;
      shadow_values_q <= '0;
      shadow_null_q   <= '1;
    end else begin
      state_q       <= state_d;
      tick_q        <= tick_d;
      shadow_full_q <= shadow_full_d;
      if (shadow_capture) begin
        shadow_values_q <= in_if.in_values;
        shadow_null_q   <= in_if.in_null;
      end
    end
  end

  always_comb begin
    state_d          = state_q;
    tick_d           = tick_q;
    shadow_full_d    = shadow_full_q;
    shadow_capture   = 1'b0;
    load_en          = 1'b0;
    load_from_shadow = 1'b0;
    load_clear       = 1'b0;
    xfer             = in_if.in_valid && !shadow_full_q;
    wrap             = (tick_q == TICK_LAST);
    case (state_q)
      IDLE: begin
        tick_d = '0;
`ifdef GAMMA_FREERUN_EN
        state_d = RUN;
`else
        if (xfer) begin
          load_en = 1'b1;
          state_d = RUN;
        end
`endif
      end
      RUN: begin
        if (wrap) begin
          tick_d = '0;
          if (shadow_full_q) begin
            load_en          = 1'b1;
            load_from_shadow = 1'b1;
            shadow_full_d    = 1'b0;
          end else if (xfer) begin
            load_en = 1'b1;
          end else begin
`ifdef GAMMA_FREERUN_EN
            // Next gamma has no data: load all-null so it stays silent.
            load_en    = 1'b1;
            load_clear = 1'b1;
`else
            state_d = IDLE;
`endif
          end
        end else begin
          tick_d = tick_q + 1'b1;
          if (xfer) begin
            shadow_capture = 1'b1;
            shadow_full_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_if.in_ready = !shadow_full_q;
    tick           = tick_q;
    busy           = (state_q == RUN);
    gamma_start    = (state_q == RUN) && (tick_q == '0);
  end

  for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_channel
    logic [VALUE_WIDTH-1:0] ch_value;
    logic                   ch_null;

    always_comb begin
      ch_value = load_from_shadow ? shadow_values_q[i*VALUE_WIDTH +: VALUE_WIDTH]
                                  : in_if.in_values[i*VALUE_WIDTH +: VALUE_WIDTH];
      ch_null  = load_clear || (load_from_shadow ? shadow_null_q[i] : in_if.in_null[i]);
    end

    temporal_channel #(
      .VALUE_WIDTH(VALUE_WIDTH)
    ) u_channel (
      .aclk      (aclk),
      .grst      (grst),
      .load      (load_en),
      .load_value(ch_value),
      .load_null (ch_null),
      .run       (busy),
      .tick      (tick_q),
      .spike     (spikes[i])
    );
  end
endmodule

// File: tb/tb_gamma_temporal_encoder.sv
module tb_gamma_temporal_encoder;
  import gamma_pkg::*;

  logic aclk = 1'b0;
  logic grst = 1'b1;
  always #5 aclk = ~aclk;

  // DUT A: G=16, 4 channels
  gamma_temporal_encoder_if #(.NUM_CHANNELS(4), .VALUE_WIDTH(4)) bus_a ();
  logic [3:0] spikes_a;
  logic [3:0] tick_a;
  logic       gs_a, busy_a;

  gamma_temporal_encoder #(
    .GAMMA_CYCLE_WIDTH(16), .NUM_CHANNELS(4), .VALUE_WIDTH(4)
  ) dut_a (
    .aclk(aclk), .grst(grst), .in_if(bus_a),
    .spikes(spikes_a), .tick(tick_a), .gamma_start(gs_a), .busy(busy_a)
  );

  // DUT B: G=12 (non power of two), 2 channels
  gamma_temporal_encoder_if #(.NUM_CHANNELS(2), .VALUE_WIDTH(4)) bus_b ();
  logic [1:0] spikes_b;
  logic [3:0] tick_b;
  logic       gs_b, busy_b;

  gamma_temporal_encoder #(
    .GAMMA_CYCLE_WIDTH(12), .NUM_CHANNELS(2), .VALUE_WIDTH(4)
  ) dut_b (
    .aclk(aclk), .grst(grst), .in_if(bus_b),
    .spikes(spikes_b), .tick(tick_b), .gamma_start(gs_b), .busy(busy_b)
  );

  typedef struct {
    logic [15:0] values;   // {ch3,ch2,ch1,ch0}
    logic [3:0]  nulls;
    int unsigned probe;
    logic [3:0]  exp_spikes;
  } vec_t;

  vec_t        tbl[10];
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int unsigned cyc   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step(input int unsigned n);
    for (int unsigned k = 0; k < n; k++) begin
      @(posedge aclk);
      #1;
      cyc++;
    end
  endtask

  task automatic reset_all();
    grst = 1'b1;
    step(1);
    grst = 1'b0;
  endtask

  // Offer a vector for exactly one edge on DUT A.
  task automatic send_a(input logic [15:0] values, input logic [3:0] nulls);
    bus_a.in_values = values;
    bus_a.in_null   = nulls;
    bus_a.in_valid  = 1'b1;
    step(1);
    bus_a.in_valid  = 1'b0;
  endtask

  int unsigned gs_cyc0, gs_cyc1, bad_cnt;

  initial begin
    bus_a.in_valid = 1'b0; bus_a.in_values = '0; bus_a.in_null = '0;
    bus_b.in_valid = 1'b0; bus_b.in_values = '0; bus_b.in_null = '0;

    tbl[0] = '{16'h7F03, 4'b1000,  0, 4'b0010};
    tbl[1] = '{16'h7F03, 4'b1000,  3, 4'b0011};
    tbl[2] = '{16'h7F03, 4'b1000, 14, 4'b0011};
    tbl[3] = '{16'h7F03, 4'b1000, 15, 4'b0111};
    tbl[4] = '{16'h4321, 4'b0000,  2, 4'b0011};
    tbl[5] = '{16'h4321, 4'b0101,  4, 4'b1010};
    tbl[6] = '{16'h0000, 4'b0000,  0, 4'b1111};
    tbl[7] = '{16'hFFFF, 4'b0000, 14, 4'b0000};
    tbl[8] = '{16'hFFFF, 4'b0000, 15, 4'b1111};
    tbl[9] = '{16'h9988, 4'b0000,  8, 4'b0011};

    // Reset state
    step(2);
    reset_all();
    check("rst_tick",     32'(tick_a),   0);
    check("rst_spikes",   32'(spikes_a), 0);
    check("rst_busy",     32'(busy_a),   0);
    check("rst_gs",       32'(gs_a),     0);
    check("rst_ready",    32'(bus_a.in_ready), 1);
    check("rst_b_ready",  32'(bus_b.in_ready), 1);

    // Table: one gamma per record, probe a tick
    for (int unsigned r = 0; r < 10; r++) begin
      reset_all();
      send_a(tbl[r].values, tbl[r].nulls);
      step(tbl[r].probe);
      check($sformatf("tbl%0d_tick", r),   32'(tick_a),   32'(tbl[r].probe));
      check($sformatf("tbl%0d_spikes", r), 32'(spikes_a), 32'(tbl[r].exp_spikes));
      check($sformatf("tbl%0d_busy", r),   32'(busy_a),   1);
      check($sformatf("tbl%0d_gs", r),     32'(gs_a),     32'(tbl[r].probe == 0));
    end

    // Single gamma then IDLE
    reset_all();
    send_a(16'h7F03, 4'b1000);
    step(15);
    check("single_t15_spikes", 32'(spikes_a), 32'b0111);
    step(1);
    check("single_end_busy",   32'(busy_a),   0);
    check("single_end_spikes", 32'(spikes_a), 0);
    check("single_end_tick",   32'(tick_a),   0);
    check("single_end_gs",     32'(gs_a),     0);

    // Back-to-back: second vector at tick 5 fills the shadow
    reset_all();
    send_a(16'h7F03, 4'b1000);
    check("b2b_gs0", 32'(gs_a), 1);
    gs_cyc0 = cyc;
    step(5);
    check("b2b_ready_t5", 32'(bus_a.in_ready), 1);
    send_a(16'h6420, 4'b0000);
    check("b2b_tick6",     32'(tick_a), 6);
    check("b2b_ready_t6",  32'(bus_a.in_ready), 0);
    bad_cnt = 0;
    for (int unsigned t = 7; t <= 15; t++) begin
      step(1);
      if (bus_a.in_ready !== 1'b0 || gs_a !== 1'b0) bad_cnt++;
    end
    check("b2b_ready_low_window", 32'(bad_cnt), 0);
    check("b2b_t15_spikes", 32'(spikes_a), 32'b0111);
    step(1);
    gs_cyc1 = cyc;
    check("b2b_gs1",        32'(gs_a), 1);
    check("b2b_busy",       32'(busy_a), 1);
    check("b2b_tick0",      32'(tick_a), 0);
    check("b2b_ready_wrap", 32'(bus_a.in_ready), 1);
    check("b2b_spikes_t0",  32'(spikes_a), 32'b0001);
    check("b2b_gs_spacing", 32'(gs_cyc1 - gs_cyc0), 16);
    step(3);
    check("b2b_spikes_t3",  32'(spikes_a), 32'b0011);

    // Transfer on the wrap cycle with empty shadow: bypass into active
    reset_all();
    send_a(16'h4321, 4'b0000);
    step(15);
    check("wrapx_tick15",  32'(tick_a), 15);
    check("wrapx_ready",   32'(bus_a.in_ready), 1);
    send_a(16'h9900, 4'b0000);
    check("wrapx_tick0",   32'(tick_a), 0);
    check("wrapx_busy",    32'(busy_a), 1);
    check("wrapx_gs",      32'(gs_a), 1);
    check("wrapx_spikes0", 32'(spikes_a), 32'b0011);
    step(9);
    check("wrapx_spikes9", 32'(spikes_a), 32'b1111);

    // Reset at tick 9 with shadow full discards everything
    reset_all();
    send_a(16'h7F03, 4'b1000);
    step(2);
    send_a(16'h6420, 4'b0000);
    check("rstmid_ready_full", 32'(bus_a.in_ready), 0);
    step(6);
    check("rstmid_tick9", 32'(tick_a), 9);
    reset_all();
    check("rstmid_spikes", 32'(spikes_a), 0);
    check("rstmid_tick",   32'(tick_a), 0);
    check("rstmid_busy",   32'(busy_a), 0);
    check("rstmid_ready",  32'(bus_a.in_ready), 1);
    bad_cnt = 0;
    for (int unsigned t = 0; t < 20; t++) begin
      step(1);
      if (busy_a !== 1'b0 || spikes_a !== 4'b0000) bad_cnt++;
    end
    check("rstmid_stays_idle", 32'(bad_cnt), 0);

    // G=12: value 5 rises at tick 5, value 13 never rises, wrap after tick 11
    reset_all();
    bus_b.in_values = 8'hD5;
    bus_b.in_null   = 2'b00;
    bus_b.in_valid  = 1'b1;
    step(1);
    bus_b.in_valid  = 1'b0;
    check("g12_gs0",     32'(gs_b), 1);
    step(4);
    check("g12_t4",      32'(spikes_b), 32'b00);
    step(1);
    check("g12_t5",      32'(spikes_b), 32'b01);
    step(6);
    check("g12_tick11",  32'(tick_b), 11);
    check("g12_t11",     32'(spikes_b), 32'b01);
    step(1);
    check("g12_end_busy",   32'(busy_b), 0);
    check("g12_end_tick",   32'(tick_b), 0);
    check("g12_end_spikes", 32'(spikes_b), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/gamma_temporal_encoder.md
Name: gamma_temporal_encoder

Overview:
- Upstream stage of the temporal mux/compute datapath.
- Converts binary channel values into rising-edge temporal codes aligned to a gamma cycle.
- Each spike line rises at tick equal to its value and holds high until the gamma cycle ends.
- Double-buffered valid/ready input lets the next gamma's values load while the current gamma plays out.

Parameters:
GAMMA_CYCLE_WIDTH, 16, ticks per gamma cycle (≥2).
NUM_CHANNELS, 16, number of temporal output lines.
VALUE_WIDTH, $clog2(GAMMA_CYCLE_WIDTH), bits per channel value.

Ports:
aclk  input  1  clock.
grst  input  1  reset, synchronous, active-high.
in_valid  input  1  value vector offered.
in_ready  output  1  shadow buffer free.
in_values  input  NUM_CHANNELS*VALUE_WIDTH  channel i in bits [i*VALUE_WIDTH +: VALUE_WIDTH].
in_null  input  NUM_CHANNELS  1 = channel never spikes (infinity).
spikes  output  NUM_CHANNELS  rising-edge temporal code.
tick  output  VALUE_WIDTH  current tick within gamma.
gamma_start  output  1  high during tick 0 of each running gamma.
busy  output  1  high in RUN.

Behaviour:
- Reset (grst high at aclk edge):
  - state=IDLE, tick=0, spikes=0, gamma_start=0, busy=0.
  - Shadow empties, so in_ready=1 in the following cycle.
  - Reset mid-gamma aborts the cycle immediately and discards both active and shadow values.
- Handshake:
  - in_ready = !shadow_full (registered state).
  - Transfer occurs when in_valid && in_ready.
  - in_values and in_null are sampled only on transfer.
- States: IDLE, RUN.
- IDLE:
  - tick=0, spikes=0.
  - On transfer, data loads directly into the active register, bypassing the shadow.
  - Next cycle: RUN with tick=0 and gamma_start=1.
- RUN:
  - tick increments by 1 each cycle.
  - At tick==GAMMA_CYCLE_WIDTH-1 (wrap cycle), the next state is chosen in this priority order:
    (a) Shadow full: active<=shadow, shadow empties, tick<=0, stay RUN.
    (b) Shadow empty and a transfer occurs this cycle: active<=incoming data directly, tick<=0, stay RUN.
    (c) Otherwise: IDLE, tick<=0, spikes<=0.
  - A transfer in a non-wrap cycle fills the shadow.
- Output timing (registered, aligned with tick):
  - In any RUN cycle with tick==t: spikes[i] = !null_i && (value_i <= t).
  - A value of 0 gives spikes[i] high during tick 0.
  - Values ≥ GAMMA_CYCLE_WIDTH (non-power-of-2 case) are treated as null.
  - All spikes drop to 0 at tick 0 of the next gamma before re-evaluation. No line stays high across a boundary unless its new value is 0.
- Back-to-back gammas have no idle cycle between them.
- Latency: a transfer in IDLE at cycle n gives tick 0 at cycle n+1.
- tick width arithmetic: the wrap compare is against GAMMA_CYCLE_WIDTH-1. The counter never reaches GAMMA_CYCLE_WIDTH.
- gamma_start=1 exactly when state==RUN && tick==0.

Optional Feature:
GAMMA_FREERUN_EN
- Defined:
  - After reset, the counter runs continuously and IDLE is never entered; busy=1 always.
  - gamma_start pulses every GAMMA_CYCLE_WIDTH cycles.
  - A gamma with no loaded data outputs spikes=0.
  - Data transferred while no gamma is loaded goes to the shadow and is applied at the next wrap. There is no IDLE bypass.
- Undefined: IDLE/RUN behaviour as above.

Decomposition:
- Package gamma_pkg holds:
  - state typedef enum {IDLE, RUN};
  - localparam helpers for VALUE_WIDTH;
  - a channel_value_t typedef.
- Sub-module temporal_channel, one per channel via generate. It holds active value/null and outputs spike = !null && value <= tick.
- Top level owns the FSM, tick counter and shadow buffer.

Test Plan:
- Reset then a single transfer: values {3,0,15,7}, null={0,0,0,1}, G=16. Expected: tick0 spikes=0010b; tick3 spikes=0011b; tick15 spikes=0111b; then IDLE with spikes=0 and busy=0.
- Back-to-back: second vector {1,...} transferred at tick 5. Expected: in_ready=0 from tick 6 until the wrap; second gamma starts with no gap; gamma_start pulses at cycles 16 apart.
- Transfer exactly on the wrap cycle with shadow empty. Expected: next cycle tick=0, RUN, new values active (bypass path).
- grst asserted at tick 9 with shadow full. Expected: next cycle spikes=0, tick=0, IDLE, in_ready=1; old data never appears.
- Value 5 on G=12 (VALUE_WIDTH=4) with value 13. Expected: value-5 line high from tick 5; value-13 line never rises; wrap after tick 11.
- GAMMA_FREERUN_EN: no data after reset. Expected: gamma_start every 16 cycles with spikes=0; a transfer at tick 4 is applied at the following tick 0.
